// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: segmented, pipelined carry-lookahead adder/subtractor.
// One SEG-bit segment is summed per stage, LSB segment first, using bit
// lookahead inside 4-bit groups and group lookahead across the segment.
// Carries, not-yet-summed operand bits and finished sum bits travel down
// the pipe together, so the full result arrives aligned in the last stage.
// The whole pipe advances as one; it freezes only while a finished result
// is waiting for out_ready.
// Optional feature (macro CLA_PIPE_SAT_EN): on signed overflow s saturates
// to the largest/smallest representable value. Without the macro s wraps
// modulo 2^WIDTH and overflow is only flagged on ovf.

module cla_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);
    localparam int NSEG = WIDTH / SEG;
    localparam int NGRP = SEG / 4;

    // Stage k (k < NSEG-1) keeps the a/b bits above its segment plus the
    // (k+1)*SEG sum bits finished so far; both are packed into flat vectors.
    localparam int OPT_RAW = 2 * (NSEG - 1) * WIDTH - SEG * (NSEG - 1) * NSEG;
    localparam int OPT     = (OPT_RAW > 0) ? OPT_RAW : 1;
    localparam int SMT_RAW = SEG * (NSEG - 1) * NSEG / 2;
    localparam int SMT     = (SMT_RAW > 0) ? SMT_RAW : 1;

    logic [OPT-1:0]   ops_q, ops_d;
    logic [SMT-1:0]   sums_q, sums_d;
    logic [NSEG-1:0]  v_q, v_d;
    logic [NSEG-1:0]  c_q, c_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             ovf_q, ovf_d;
    logic             adv;
    logic [WIDTH-1:0] b_in;
    logic             c0;

    // SEG-bit add: bit lookahead inside each 4-bit group, flat group
    // lookahead across the segment (no carry rippling group to group).
    function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           cin);
        logic [SEG-1:0]  g, p, sm;
        logic [NGRP-1:0] gg, gp;
        logic [NGRP:0]   gc;
        logic [3:0]      g4, p4, cb;
        logic            term;
        g = x & y;
        p = x ^ y;
        for (int j = 0; j < NGRP; j++) begin
            g4 = g[4*j +: 4];
            p4 = p[4*j +: 4];
            gg[j] = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
                  | (p4[3] & p4[2] & p4[1] & g4[0]);
            gp[j] = &p4;
        end
        gc[0] = cin;
        for (int j = 1; j <= NGRP; j++) begin
            term = cin;
            for (int m = 0; m < j; m++) term = term & gp[m];
            gc[j] = term;
            for (int i = 0; i < j; i++) begin
                term = gg[i];
                for (int m = i + 1; m < j; m++) term = term & gp[m];
                gc[j] = gc[j] | term;
            end
        end
        sm = '0;
        for (int j = 0; j < NGRP; j++) begin
            g4 = g[4*j +: 4];
            p4 = p[4*j +: 4];
            cb[0] = gc[j];
            cb[1] = g4[0] | (p4[0] & gc[j]);
            cb[2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & gc[j]);
            cb[3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
                  | (p4[2] & p4[1] & p4[0] & gc[j]);
            sm[4*j +: 4] = p4 ^ cb;
        end
        return {gc[NGRP], sm};
    endfunction

    // Subtraction is a + ~b + 1.
    assign b_in = sub ? ~b : b;
    assign c0   = sub | c_in;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        localparam int PW  = WIDTH - k * SEG;
        localparam int OPI = 2 * (k - 1) * WIDTH - SEG * (k - 1) * k;
        localparam int OPO = 2 * k * WIDTH - SEG * k * (k + 1);
        localparam int SOI = SEG * (k - 1) * k / 2;
        localparam int SOO = SEG * k * (k + 1) / 2;
        logic [PW-1:0] pa, pb;
        logic          pc;
        logic [SEG:0]  r;

        if (k == 0) begin : g_src
            assign pa     = a;
            assign pb     = b_in;
            assign pc     = c0;
            assign v_d[k] = in_valid;
        end else begin : g_src
            assign pa     = ops_q[OPI +: PW];
            assign pb     = ops_q[OPI + PW +: PW];
            assign pc     = c_q[k-1];
            assign v_d[k] = v_q[k-1];
        end

        assign r      = seg_add(pa[SEG-1:0], pb[SEG-1:0], pc);
        assign c_d[k] = r[SEG];

        if (k < NSEG - 1) begin : g_mid
            assign ops_d[OPO +: PW - SEG]            = pa[PW-1:SEG];
            assign ops_d[OPO + PW - SEG +: PW - SEG] = pb[PW-1:SEG];
            if (k == 0) begin : g_sum
                assign sums_d[SOO +: SEG] = r[SEG-1:0];
            end else begin : g_sum
                assign sums_d[SOO +: (k + 1) * SEG] = {r[SEG-1:0], sums_q[SOI +: k * SEG]};
            end
        end else begin : g_last
            logic [WIDTH-1:0] raw;
            if (k == 0) begin : g_sum
                assign raw = r[SEG-1:0];
            end else begin : g_sum
                assign raw = {r[SEG-1:0], sums_q[SOI +: k * SEG]};
            end
            // pa/pb top bits are the operand signs (b already inverted for sub)
            assign ovf_d = (pa[SEG-1] == pb[SEG-1]) && (raw[WIDTH-1] != pa[SEG-1]);
`ifdef CLA_PIPE_SAT_EN
            assign s_d = !ovf_d     ? raw :
                         pa[SEG-1]  ? {1'b1, {(WIDTH-1){1'b0}}} :
                                      {1'b0, {(WIDTH-1){1'b1}}};
`else
            assign s_d = raw;
`endif
        end
    end

    if (NSEG == 1) begin : g_single
        assign ops_d  = '0;
        assign sums_d = '0;
    end

    // Pipe moves as one unit; a waiting result freezes every stage.
    assign adv = ~(v_q[NSEG-1] & ~out_ready);

    // Stage registers: synchronous reset empties the pipe and clears outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= '0;
            c_q    <= '0;
            ops_q  <= '0;
            sums_q <= '0;
            s_q    <= '0;
            ovf_q  <= 1'b0;
        end else if (adv) begin
            v_q    <= v_d;
            c_q    <= c_d;
            ops_q  <= ops_d;
            sums_q <= sums_d;
            s_q    <= s_d;
            ovf_q  <= ovf_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = v_q[NSEG-1];
    assign s         = s_q;
    assign c_out     = c_q[NSEG-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder (WIDTH=32, SEG=8): directed literal cases plus a
// randomized run scored against a plain-arithmetic reference queue.
module tb_cla_pipe_adder;
    localparam int WIDTH = 32;
    localparam int SEG   = 8;
    localparam int NSEG  = WIDTH / SEG;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              sub;
    logic              c_in;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  s;
    logic              c_out;
    logic              ovf;

    int checks = 0;
    int errors = 0;

    cla_pipe_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        int          tag;
    } exp_t;

    // Reference result from the arithmetic meaning of the operation.
    function automatic exp_t ref_calc(input logic [31:0] x, input logic [31:0] y,
                                      input logic sb, input logic ci);
        exp_t   e;
        longint sx, sy, tr, ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        if (sb) begin
            tr  = sx - sy;
            e.c = (ux >= uy);
            e.s = x - y;
        end else begin
            tr  = sx + sy + longint'(ci);
            e.c = ((ux + uy + longint'(ci)) > 64'sh0FFFFFFFF);
            e.s = x + y + {31'b0, ci};
        end
        e.o = (tr > 64'sh07FFFFFFF) || (tr < -64'sh080000000);
`ifdef CLA_PIPE_SAT_EN
        if (e.o) e.s = (tr > 0) ? 32'h7FFFFFFF : 32'h80000000;
`endif
        e.tag = 0;
        return e;
    endfunction

    exp_t q[$];
    int   adv_cnt  = 0;
    logic model_en = 1'b0;

    // Reference pipeline: an accepted op is due once the pipe has advanced
    // NSEG-1 more times after the edge that took it.
    always @(negedge clk) begin : model_blk
        logic exp_ov;
        logic adv_m;
        exp_t e;
        if (model_en) begin
            exp_ov = (q.size() > 0) && ((adv_cnt - q[0].tag) == NSEG - 1);
            chk("out_valid", out_valid, exp_ov);
            chk("in_ready", in_ready, !(exp_ov && !out_ready));
            if (exp_ov && out_valid) begin
                chk("s", s, q[0].s);
                chk("c_out", c_out, q[0].c);
                chk("ovf", ovf, q[0].o);
            end
            if (rst) begin
                q.delete();
            end else begin
                adv_m = !(exp_ov && !out_ready);
                if (exp_ov && out_ready) void'(q.pop_front());
                if (adv_m) begin
                    adv_cnt++;
                    if (in_valid) begin
                        e     = ref_calc(a, b, sub, c_in);
                        e.tag = adv_cnt;
                        q.push_back(e);
                    end
                end
            end
        end
    end

    logic        seq_en = 1'b0;
    logic [31:0] got[$];
    logic        cnt_en = 1'b0;
    int          ov_count = 0;

    always @(negedge clk) begin
        if (seq_en && out_valid && out_ready) got.push_back(s);
        if (cnt_en && out_valid) ov_count++;
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
    endtask

    task automatic lit_op(input string nm, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic tsub, input logic tcin,
                          input logic [31:0] es, input logic ec, input logic eo);
        int lat;
        lat = 0;
        @(posedge clk); #1;
        a = ta; b = tb_v; sub = tsub; c_in = tcin;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        chk({nm, "_latency"}, lat, NSEG);
        chk({nm, "_s"}, s, es);
        chk({nm, "_c_out"}, c_out, ec);
        chk({nm, "_ovf"}, ovf, eo);
    endtask

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 5))
            0:       return 32'h00000000;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h7FFFFFFF;
            3:       return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int   i;
        int   cyc;
        logic saw_stall;
        logic last_rdy;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; c_in = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        model_en = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_s", s, 32'h0);
        chk("rst_c_out", c_out, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        lit_op("wrap_add", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
        idle(2);
`ifdef CLA_PIPE_SAT_EN
        lit_op("pos_ovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1);
`else
        lit_op("pos_ovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
`endif
        idle(2);
        lit_op("sub_borrow", 32'h5, 32'h7, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0);
        idle(2);
        lit_op("sub_cin_ign", 32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        idle(2);
`ifdef CLA_PIPE_SAT_EN
        lit_op("neg_ovf", 32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h80000000, 1'b1, 1'b1);
`else
        lit_op("neg_ovf", 32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1);
`endif
        idle(2);
        lit_op("cin_add", 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0);
        idle(2);

        // back-to-back 1+1 .. 10+10 with out_ready low in cycles 6-8
        got.delete();
        seq_en = 1'b1;
        saw_stall = 1'b0;
        i = 1;
        cyc = 1;
        @(posedge clk); #1;
        while (i <= 10 && cyc < 60) begin
            in_valid = 1'b1; a = 32'(i); b = 32'(i); sub = 1'b0; c_in = 1'b0;
            out_ready = !(cyc >= 6 && cyc <= 8);
            @(negedge clk);
            if (!in_ready) saw_stall = 1'b1;
            else i++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (NSEG + 4) @(posedge clk);
        #1;
        seq_en = 1'b0;
        chk("seq_count", got.size(), 10);
        for (int k = 0; k < 10; k++)
            chk("seq_result", (k < got.size()) ? got[k] : 32'hDEADBEEF, 32'(2 * (k + 1)));
        chk("seq_stall_seen", saw_stall, 1'b1);

        // reset with two ops in flight, then a single 3+4
        idle(2);
        @(posedge clk); #1;
        in_valid = 1'b1; a = 32'd10; b = 32'd20; sub = 1'b0; c_in = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        a = 32'd30; b = 32'd40;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        ov_count = 0;
        cnt_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_s", s, 32'h0);
        lit_op("after_rst", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0);
        idle(NSEG + 3);
        cnt_en = 1'b0;
        chk("after_rst_out_count", ov_count, 1);

        // randomized traffic with random back-pressure and one mid-run reset
        last_rdy = 1'b1;
        for (int n = 0; n < 800; n++) begin
            @(posedge clk); #1;
            if (!(in_valid && !last_rdy)) begin
                in_valid = ($urandom_range(0, 9) < 7);
                a        = pick_op();
                b        = pick_op();
                sub      = $urandom_range(0, 1) == 1;
                c_in     = $urandom_range(0, 1) == 1;
            end
            out_ready = ($urandom_range(0, 9) < 7);
            rst       = (n == 400);
            @(negedge clk);
            last_rdy = in_ready;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        idle(NSEG + 6);
        chk("final_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end
endmodule

// File: doc/cla_pipe_adder.md
CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits; SHALL be a multiple of SEG.
REQ-002 Parameter SEG, default 8, bits per pipeline segment; SHALL be a multiple of 4, built from 4-bit lookahead groups.
REQ-003 Port clk, input, 1, single clock; every register samples on its rising edge.
REQ-004 Port rst, input, 1, reset; synchronous, active-high.
REQ-005 Port in_valid, input, 1, operands present on a, b, sub and c_in.
REQ-006 Port in_ready, output, 1, block accepts operands this cycle.
REQ-007 Port a, input, WIDTH, first operand.
REQ-008 Port b, input, WIDTH, second operand.
REQ-009 Port sub, input, 1, 1 = compute a - b, 0 = compute a + b.
REQ-010 Port c_in, input, 1, carry-in; ignored when sub=1.
REQ-011 Port out_valid, output, 1, result present on s, c_out and ovf.
REQ-012 Port out_ready, input, 1, consumer accepts the result.
REQ-013 Port s, output, WIDTH, sum or difference.
REQ-014 Port c_out, output, 1, carry out of the MSB (for subtraction, 1 = no borrow).
REQ-015 Port ovf, output, 1, two's-complement signed overflow of the result.

Function
REQ-016 The adder SHALL be split into NSEG = WIDTH/SEG segments, processed one segment per stage, LSB segment first.
REQ-017 Within a segment, carries SHALL be formed by 4-bit group generate/propagate and lookahead, with no ripple between groups.
REQ-018 Between segments, carry SHALL pass through a register; operand bits not yet summed SHALL be delayed, and completed sum bits de-skewed, so s is aligned at the output.
REQ-019 Subtraction SHALL use b inverted and segment-0 carry-in forced to 1.
REQ-020 Latency SHALL be exactly NSEG cycles from an accepted input (in_valid & in_ready) to out_valid, with no stall.
REQ-021 Throughput SHALL be one operation per cycle when out_ready is held 1.
REQ-022 Each stage SHALL carry a valid bit; empty stages SHALL NOT produce out_valid.
REQ-023 in_ready SHALL equal NOT (out_valid AND NOT out_ready); while 0, the whole pipeline SHALL hold its contents.
REQ-024 A held result SHALL keep s, c_out and ovf stable until out_ready=1.
REQ-025 ovf SHALL be 1 when the operand signs (b after inversion when sub=1) are equal and the result sign differs.
REQ-026 in_valid=1 while in_ready=0 SHALL be ignored, and the source SHALL hold its operands.
REQ-027 Acceptance and output consumption in the same cycle SHALL both take effect, with no bubble.

Reset
REQ-028 With rst=1 at a clock edge, all stage valid bits, out_valid, s, c_out and ovf SHALL become 0.
REQ-029 Reset mid-operation SHALL discard all in-flight operations; none SHALL emerge afterwards.
REQ-030 During and after the reset cycle, in_ready SHALL read 1, because out_valid=0.

Configuration
REQ-031 Macro CLA_PIPE_SAT_EN defined: when ovf=1, s SHALL saturate to 2^(WIDTH-1)-1 for positive overflow or -2^(WIDTH-1) for negative overflow; ovf is still reported.
REQ-032 Macro CLA_PIPE_SAT_EN undefined: s SHALL wrap modulo 2^WIDTH, with ovf reported only.

Verification (WIDTH=32, SEG=8)
REQ-033 a=0xFFFFFFFF, b=0x00000001, sub=0, c_in=0, out_ready=1 -> 4 cycles later: s=0x00000000, c_out=1, ovf=0.
REQ-034 a=0x7FFFFFFF, b=1, sub=0 -> ovf=1; s=0x80000000 without macro, s=0x7FFFFFFF with CLA_PIPE_SAT_EN.
REQ-035 a=5, b=7, sub=1 -> s=0xFFFFFFFE, c_out=0, ovf=0.
REQ-036 Back-to-back sequence 1+1, 2+2, ... 10+10, out_ready=0 for cycles 6-8 -> in_ready=0 during the stall, no loss or duplication, results 2..20 in order.
REQ-037 Assert rst after 2 operations accepted, then one new operation 3+4 -> only s=7 appears, 4 cycles after acceptance.
